// File: rtl/shared_ram_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shared_ram_rr_arbiter
// Purpose  : Round-robin arbiter granting NUM_CORES word cores one-at-a-time
//            access to a single-port shared RAM. Each grant performs a single
//            write or read, then pulses a one-cycle ACK to the winning core.
// Ports    : clk, rst_n             - clock (rising edge), async active-low reset
//            i_req_we / i_req_rr    - per-core write / read request levels
//            i_req_addr/i_req_wdata - per-core address / write data, packed
//            o_req_ack              - one-hot completion pulse
//            o_req_rdata            - read data, valid in the ACK cycle of a read
//            o_ram_addr/o_ram_wdata - latched RAM address / write data
//            o_ram_we / o_ram_re    - RAM write / read strobes
//            i_ram_rdata            - RAM read data
//            o_grant_idx            - index of the core currently/last served
//            o_busy                 - high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module shared_ram_rr_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int RAM_RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CORES-1:0]          i_req_we,
    input  logic [NUM_CORES-1:0]          i_req_rr,
    input  logic [NUM_CORES*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   i_req_wdata,
    output logic [NUM_CORES-1:0]          o_req_ack,
    output logic [DATA_W-1:0]             o_req_rdata,
    output logic [ADDR_W-1:0]             o_ram_addr,
    output logic [DATA_W-1:0]             o_ram_wdata,
    output logic                          o_ram_we,
    output logic                          o_ram_re,
    input  logic [DATA_W-1:0]             i_ram_rdata,
    output logic [$clog2(NUM_CORES)-1:0]  o_grant_idx,
    output logic                          o_busy
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int CNT_W = (RAM_RD_LAT > 1) ? $clog2(RAM_RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_WAIT  = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_grant;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [CNT_W-1:0]    r_cnt;

    logic [NUM_CORES-1:0] w_req;
    logic                 w_found;
    logic [IDX_W-1:0]     w_win;

    assign w_req = i_req_we | i_req_rr;

    // (base + off) mod NUM_CORES without a divider; off is always < NUM_CORES.
    function automatic logic [IDX_W-1:0] f_rot(input logic [IDX_W-1:0] base,
                                               input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CORES) begin
            s = s - NUM_CORES;
        end
        return IDX_W'(s);
    endfunction

    // Rotating-priority search: the first requester at or after r_ptr wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!w_found && w_req[f_rot(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = f_rot(r_ptr, k);
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next    = r_state;
        o_ram_we  = 1'b0;
        o_ram_re  = 1'b0;
        o_req_ack = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    // A core asking for both gets its write first.
                    w_next = i_req_we[w_win] ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                o_ram_we = 1'b1;
                w_next   = S_ACK;
            end
            S_READ: begin
                o_ram_re = 1'b1;
                w_next   = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                o_req_ack[r_grant] = 1'b1;
                w_next             = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: grant latch, RAM address/data copies, read capture, pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_win;
                        r_addr  <= i_req_addr[w_win*ADDR_W +: ADDR_W];
                        r_wdata <= i_req_wdata[w_win*DATA_W +: DATA_W];
                    end
                end
                S_READ: begin
                    r_cnt <= CNT_W'(RAM_RD_LAT - 1);
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rdata <= i_ram_rdata;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ACK: begin
                    // The served core drops to lowest priority next round.
                    r_ptr <= (r_grant == IDX_W'(NUM_CORES - 1)) ? '0 : r_grant + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_req_rdata = r_rdata;
    assign o_ram_addr  = r_addr;
    assign o_ram_wdata = r_wdata;
    assign o_grant_idx = r_grant;
    assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
